// File: rtl/stepper_pkg.sv
// stepper_pkg: coil phase constants, fault codes, FSM encoding and phase helpers for stepper_phase_decoder
package stepper_pkg;
  localparam logic [3:0] PH_IDLE = 4'b0000;
  localparam logic [3:0] PH_P1   = 4'b0001;
  localparam logic [3:0] PH_P2   = 4'b0010;
  localparam logic [3:0] PH_P3   = 4'b0100;
  localparam logic [3:0] PH_P4   = 4'b1000;
  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_SKIP    = 2'b10;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;
  // forward order P1->P4->P3->P2 is a rotate right of the one-hot pattern
  function automatic logic [3:0] phase_fwd(input logic [3:0] p);
    return {p[0], p[3:1]};
  endfunction
  function automatic logic [3:0] phase_rev(input logic [3:0] p);
    return {p[2:0], p[3]};
  endfunction
  function automatic logic is_phase(input logic [3:0] p);
    return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
  endfunction
endpackage

// File: rtl/stepper_sync.sv
// stepper_sync: two-flop synchronizer, async active-low reset to 0
// ports: clk, rst (active-low async), d (async input), q (synchronized output)
module stepper_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  assign q = sync_q;
endmodule

// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder: tracks stepper coil phases into a signed position, direction, motion and fault status
// ports: clk, rst (active-low async), coil[3:0], clr (sync clear of position/fault),
//        position[POS_W-1:0], step_pulse, dir, moving, fault[1:0]
// option: define STEPPER_DEC_SYNC_EN to put a 2-flop synchronizer in front of the coil sample
module stepper_phase_decoder
  import stepper_pkg::*;
#(
  parameter int POS_W        = 16,
  parameter int STALL_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       coil,
  input  logic             clr,
  output logic [POS_W-1:0] position,
  output logic             step_pulse,
  output logic             dir,
  output logic             moving,
  output logic [1:0]       fault
);
  localparam int CNT_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STALL_CYCLES);
  logic [3:0]       coil_s;
  logic [3:0]       coil_q;
  logic [0:0]       state_q, state_d;
  logic [3:0]       last_phase_q, last_phase_d;
  logic [POS_W-1:0] position_q, position_d;
  logic             step_pulse_q, step_pulse_d;
  logic             dir_q, dir_d;
  logic             moving_q, moving_d;
  logic [1:0]       fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef STEPPER_DEC_SYNC_EN
  stepper_sync #(.W(4)) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (coil),
    .q  (coil_s)
  );
`else
  assign coil_s = coil;
`endif
  always_comb begin
    state_d      = state_q;
    last_phase_d = last_phase_q;
    position_d   = position_q;
    dir_d        = dir_q;
    fault_d      = fault_q;
    step_pulse_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (is_phase(coil_q)) begin
        last_phase_d = coil_q;
        state_d      = ST_TRACK;
      end else if (coil_q != PH_IDLE) fault_d = FLT_ILLEGAL;
    end else if (coil_q == PH_IDLE) state_d = ST_IDLE;
    else if (!is_phase(coil_q)) fault_d = FLT_ILLEGAL;
    else if (coil_q == phase_fwd(last_phase_q)) begin
      position_d   = position_q + POS_W'(1);
      dir_d        = 1'b0;
      step_pulse_d = 1'b1;
      last_phase_d = coil_q;
    end else if (coil_q == phase_rev(last_phase_q)) begin
      position_d   = position_q - POS_W'(1);
      dir_d        = 1'b1;
      step_pulse_d = 1'b1;
      last_phase_d = coil_q;
    end else if (coil_q != last_phase_q) begin
      fault_d      = FLT_SKIP;
      last_phase_d = coil_q;
    end
    // clear cancels the step count but leaves phase tracking running
    if (clr) begin
      position_d   = '0;
      fault_d      = FLT_NONE;
      step_pulse_d = 1'b0;
      dir_d        = dir_q;
    end
    cnt_d    = step_pulse_d ? '0 : (cnt_q == CNT_SAT ? cnt_q : cnt_q + CNT_W'(1));
    moving_d = cnt_d < CNT_SAT;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      coil_q       <= PH_IDLE;
      state_q      <= ST_IDLE;
      last_phase_q <= PH_IDLE;
      position_q   <= '0;
      step_pulse_q <= 1'b0;
      dir_q        <= 1'b0;
      moving_q     <= 1'b0;
      fault_q      <= FLT_NONE;
      cnt_q        <= CNT_SAT;
    end else begin
      coil_q       <= coil_s;
      state_q      <= state_d;
      last_phase_q <= last_phase_d;
      position_q   <= position_d;
      step_pulse_q <= step_pulse_d;
      dir_q        <= dir_d;
      moving_q     <= moving_d;
      fault_q      <= fault_d;
      cnt_q        <= cnt_d;
    end
  assign position   = position_q;
  assign step_pulse = step_pulse_q;
  assign dir        = dir_q;
  assign moving     = moving_q;
  assign fault      = fault_q;
endmodule

// File: tb/tb_stepper_phase_decoder.sv
// tb_stepper_phase_decoder: randomized and directed check of stepper_phase_decoder against a phase-index reference model
module tb_stepper_phase_decoder;
  localparam int SC = 8;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  coil = 4'b0000;
  logic [15:0] position;
  logic        step_pulse;
  logic        dir;
  logic        moving;
  logic [1:0]  fault;
  int total = 0;
  int bad = 0;
  int pulses = 0;
  int cur = 0;
  stepper_phase_decoder #(.POS_W(16), .STALL_CYCLES(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .coil      (coil),
    .clr       (clr),
    .position  (position),
    .step_pulse(step_pulse),
    .dir       (dir),
    .moving    (moving),
    .fault     (fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // phase index k in forward order: P1, P4, P3, P2
  function automatic logic [3:0] ph(input int k);
    case (k & 3)
      0: return 4'b0001;
      1: return 4'b1000;
      2: return 4'b0100;
      default: return 4'b0010;
    endcase
  endfunction
  function automatic int find(input logic [3:0] c);
    for (int k = 0; k < 4; k++) if (ph(k) == c) return k;
    return -1;
  endfunction
  logic [3:0] m_cq, m_s1, m_s2;
  bit m_trk, m_dir, m_pulse, m_mov;
  int m_idx, m_pos, m_flt, m_since;
  task automatic m_reset();
    m_cq = 0; m_s1 = 0; m_s2 = 0; m_trk = 0; m_idx = 0; m_pos = 0;
    m_dir = 0; m_pulse = 0; m_flt = 0; m_since = SC; m_mov = 0;
  endtask
  task automatic m_clock(input logic [3:0] c, input bit cl);
    int k, d;
    k = find(m_cq);
    m_pulse = 0;
    if (!m_trk) begin
      if (k >= 0) begin m_trk = 1; m_idx = k; end
      else if (m_cq != 0) m_flt = 1;
    end else if (m_cq == 0) m_trk = 0;
    else if (k < 0) m_flt = 1;
    else begin
      d = (k - m_idx + 4) % 4;
      if (d == 1 && !cl) begin m_pos = (m_pos + 1) % 65536; m_dir = 0; m_pulse = 1; end
      if (d == 3 && !cl) begin m_pos = (m_pos + 65535) % 65536; m_dir = 1; m_pulse = 1; end
      if (d == 2) m_flt = 2;
      m_idx = k;
    end
    if (cl) begin m_pos = 0; m_flt = 0; end
    m_since = m_pulse ? 0 : (m_since < SC ? m_since + 1 : SC);
    m_mov = m_since < SC;
`ifdef STEPPER_DEC_SYNC_EN
    m_cq = m_s2; m_s2 = m_s1; m_s1 = c;
`else
    m_cq = c;
`endif
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".position"}, position, m_pos);
    chk({tag, ".step_pulse"}, step_pulse, m_pulse);
    chk({tag, ".dir"}, dir, m_dir);
    chk({tag, ".moving"}, moving, m_mov);
    chk({tag, ".fault"}, fault, m_flt);
  endtask
  task automatic cyc(input logic [3:0] c, input bit cl);
    coil = c;
    clr = cl;
    @(posedge clk);
    m_clock(c, cl);
    @(negedge clk);
    if (step_pulse) pulses++;
    check_all("cyc");
  endtask
  task automatic hold(input logic [3:0] c, input int n);
    repeat (n) cyc(c, 1'b0);
  endtask
  task automatic do_reset();
    #2 rst = 1'b0;
    #1 m_reset();
    check_all("async_rst");
    chk("async_rst.pos0", position, 0);
    chk("async_rst.moving0", moving, 0);
    @(negedge clk) rst = 1'b1;
  endtask
  initial begin
    m_reset();
    #12;
    check_all("reset");
    @(negedge clk) rst = 1'b1;
    pulses = 0;
    hold(4'b0001, 3); hold(4'b1000, 3); hold(4'b0100, 3); hold(4'b0010, 3); hold(4'b0001, 3);
    hold(4'b0001, 4);
    chk("fwd.pulses", pulses, 4);
    chk("fwd.pos", position, 4);
    chk("fwd.dir", dir, 0);
    chk("fwd.fault", fault, 0);
    cyc(4'b0001, 1'b1);
    hold(4'b0010, 3); hold(4'b0100, 3); hold(4'b0100, 4);
    chk("rev.pos", position, 16'hFFFE);
    chk("rev.dir", dir, 1);
    hold(4'b0000, 4); hold(4'b0001, 4);
    cyc(4'b0001, 1'b1);
    hold(4'b0100, 6);
    chk("skip.fault", fault, 2);
    chk("skip.pos", position, 0);
    hold(4'b1000, 6);
    chk("skip_rev.pos", position, 16'hFFFF);
    chk("skip_rev.dir", dir, 1);
    hold(4'b0011, 6);
    chk("illegal.fault", fault, 1);
    hold(4'b1000, 4);
    chk("illegal.sticky", fault, 1);
    cyc(4'b1000, 1'b1);
    chk("clr.fault", fault, 0);
    chk("clr.pos", position, 0);
    hold(4'b0100, 6);
    chk("held_phase.pos", position, 1);
    hold(4'b0100, 12);
    chk("stall.moving", moving, 0);
    cyc(4'b0100, 1'b1);
    for (int i = 1; i <= 32767; i++) cyc(ph(2 + i), 1'b0);
    hold(ph(2 + 32767), 4);
    chk("wrap.7fff", position, 16'h7FFF);
    hold(ph(2 + 32768), 4);
    chk("wrap.8000", position, 16'h8000);
    hold(ph(2 + 32769), 2);
    do_reset();
    cur = 0;
    for (int it = 0; it < 3000; it++) begin
      int r, n, a;
      logic [3:0] v;
      r = $urandom_range(0, 15);
      n = $urandom_range(1, 3);
      a = $urandom_range(0, 3);
      if (r < 5) begin cur = (cur + 1) % 4; v = ph(cur); end
      else if (r < 10) begin cur = (cur + 3) % 4; v = ph(cur); end
      else if (r == 10) begin cur = (cur + 2) % 4; v = ph(cur); end
      else if (r == 11) v = 4'b0000;
      else if (r == 12) v = ph(a) | ph(a + 1 + $urandom_range(0, 1));
      else if (r == 13) v = 4'b1111;
      else v = ph(cur);
      for (int j = 0; j < n; j++) cyc(v, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
    end
    hold(4'b0000, 12);
    chk("final.moving", moving, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
